clk_enable_gen_n: RTL and testbench

//  Multi-channel clock-enable generator: all logic stays on the single global clock; no gated or fabric-routed clocks.

---
 rtl/clk_enable_gen_n_pkg.sv | 18 +
 rtl/clk_enable_gen_n_ce_channel.sv | 131 +++++++++++++
 rtl/clk_enable_gen_n.sv | 62 ++++++
 tb/tb_clk_enable_gen_n.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_enable_gen_n_pkg.sv
// Shared definitions for the multi-channel clock-enable generator.
//   ch_state_e      : per-channel FSM state encoding (OFF, ARMED, RUN, DRAIN)
//   period_from_div : number of clock cycles between ce pulses for a divide value
package clk_enable_gen_n_pkg;

  typedef enum logic [1:0] {
    StOff   = 2'd0,
    StArmed = 2'd1,
    StRun   = 2'd2,
    StDrain = 2'd3
  } ch_state_e;

  // A divide value of n yields one ce pulse every n+1 cycles.
  function automatic int unsigned period_from_div(input int unsigned div);
    return div + 1;
  endfunction

endpackage

// File: rtl/clk_enable_gen_n_ce_channel.sv
// One clock-enable channel: arming/alignment FSM, down-counter, shadowed divide
// value, registered ce pulse, data capture and busy flag.
// Ports:
//   clk, rst    : global clock, asynchronous active-high reset
//   en          : run request (level)
//   align_zero  : shared alignment counter is at zero this cycle
//   div_load    : pulse, sample div_val into the shadow register
//   div_val     : divide value for this channel (period = div_val+1)
//   d           : data to capture
//   ce          : registered one-cycle enable pulse
//   q           : captured data, updated on the edge after ce is high
//   busy        : channel is not OFF
module clk_enable_gen_n_ce_channel
  import clk_enable_gen_n_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             align_zero,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  input  logic             d,
  output logic             ce,
  output logic             q,
  output logic             busy
);

  ch_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] shadow;
  logic             pend;

  logic             counting;
  logic             tc;
  logic [CNT_W-1:0] next_div;

  assign counting = (state == StRun) || (state == StDrain);
  // Terminal count: the edge that issues ce and reloads the counter.
  assign tc       = counting && (cnt == '0);
  assign next_div = pend ? shadow : div_act;

  // Channel FSM, counter and registered outputs ce/busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StOff;
      busy  <= 1'b0;
      cnt   <= '0;
      ce    <= 1'b0;
    end else begin
      ce <= tc;
      if (counting) begin
        cnt <= tc ? next_div : cnt - 1'b1;
      end
      unique case (state)
        StOff: begin
          if (en) begin
            state <= StArmed;
            busy  <= 1'b1;
          end
        end
        StArmed: begin
          if (!en) begin
            state <= StOff;
            busy  <= 1'b0;
          end else if (align_zero) begin
            state <= StRun;
            cnt   <= div_act;
          end
        end
        StRun: begin
          if (!en) begin
            state <= StDrain;
          end
        end
        StDrain: begin
          // Returning to RUN keeps the running count, so the phase is unchanged.
          if (en) begin
            state <= StRun;
          end else if (tc) begin
            state <= StOff;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= StOff;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Divide value shadowing. While idle a load takes effect at once; while
  // counting it waits for the terminal count so no period is ever cut short.
  // A load on the terminal-count edge applies the older pending value now and
  // leaves the new one pending for the next period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_act <= '0;
      shadow  <= '0;
      pend    <= 1'b0;
    end else if (!counting) begin
      if (div_load) begin
        div_act <= div_val;
        shadow  <= div_val;
        pend    <= 1'b0;
      end
    end else begin
      if (tc && pend) begin
        div_act <= shadow;
        pend    <= 1'b0;
      end
      if (div_load) begin
        shadow <= div_val;
        pend   <= 1'b1;
      end
    end
  end

  // Data capture qualified by the registered ce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (ce) begin
      q <= d;
    end
  end

endmodule

// File: rtl/clk_enable_gen_n.sv
// Multi-channel clock-enable generator. Everything runs on clk; each channel
// produces a one-cycle ce pulse every div+1 cycles and captures d on it.
// Channels start on a shared free-running alignment counter so enabled
// channels keep a fixed phase relationship.
// Ports:
//   clk, rst  : global clock, asynchronous active-high reset
//   en        : per-channel run request
//   div_load  : pulse, sample div_val into all channel shadow registers
//   div_val   : packed divide values, channel i at [i*CNT_W +: CNT_W]
//   d         : per-channel capture data
//   ce        : per-channel registered enable pulse
//   q         : per-channel captured data
//   busy      : per-channel not-OFF flag
module clk_enable_gen_n
  import clk_enable_gen_n_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned ALIGN_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       en,
  input  logic                  div_load,
  input  logic [N_CH*CNT_W-1:0] div_val,
  input  logic [N_CH-1:0]       d,
  output logic [N_CH-1:0]       ce,
  output logic [N_CH-1:0]       q,
  output logic [N_CH-1:0]       busy
);

  logic [ALIGN_W-1:0] align_cnt;
  logic               align_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      align_cnt <= '0;
    end else begin
      align_cnt <= align_cnt + 1'b1;
    end
  end

  assign align_zero = (align_cnt == '0);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clk_enable_gen_n_ce_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (en[i]),
      .align_zero (align_zero),
      .div_load   (div_load),
      .div_val    (div_val[i*CNT_W +: CNT_W]),
      .d          (d[i]),
      .ce         (ce[i]),
      .q          (q[i]),
      .busy       (busy[i])
    );
  end

endmodule

// File: tb/tb_clk_enable_gen_n.sv
// Directed self-checking bench for clk_enable_gen_n. Expected ce/q/busy values
// for each cycle are queued before the clock edge and compared after it.
module tb_clk_enable_gen_n;
  import clk_enable_gen_n_pkg::*;

  localparam int unsigned N_CH    = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ALIGN_W = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N_CH-1:0]       en = '0;
  logic                  div_load = 1'b0;
  logic [N_CH*CNT_W-1:0] div_val = '0;
  logic [N_CH-1:0]       d = '0;
  logic [N_CH-1:0]       ce;
  logic [N_CH-1:0]       q;
  logic [N_CH-1:0]       busy;

  always #5 clk = ~clk;

  clk_enable_gen_n #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .ALIGN_W (ALIGN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_load (div_load),
    .div_val  (div_val),
    .d        (d),
    .ce       (ce),
    .q        (q),
    .busy     (busy)
  );

  typedef struct {
    string      tag;
    logic [3:0] ce_e;
    logic [3:0] ce_m;
    logic [3:0] q_e;
    logic [3:0] q_m;
    logic [3:0] b_e;
    logic [3:0] b_m;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   t = 0;  // cycles since reset release; equals the DUT alignment count mod 16

  localparam logic [3:0] ALL = 4'b1111;

  task automatic push(input string tag, input logic [3:0] ce_e, input logic [3:0] ce_m,
                      input logic [3:0] q_e, input logic [3:0] q_m,
                      input logic [3:0] b_e, input logic [3:0] b_m);
    exp_t e;
    e.tag = tag; e.ce_e = ce_e; e.ce_m = ce_m;
    e.q_e = q_e; e.q_m = q_m; e.b_e = b_e; e.b_m = b_m;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty t=%0d no expected entry queued", t);
    end else begin
      e = sb.pop_front();
      assert (((ce & e.ce_m) === (e.ce_e & e.ce_m)) && ((q & e.q_m) === (e.q_e & e.q_m)) &&
              ((busy & e.b_m) === (e.b_e & e.b_m)))
      else begin
        miscompares++;
        $error("FAIL %s t=%0d got ce=%b q=%b busy=%b want ce=%b/%b q=%b/%b busy=%b/%b (val/mask)",
               e.tag, t, ce, q, busy, e.ce_e, e.ce_m, e.q_e, e.q_m, e.b_e, e.b_m);
      end
    end
  endtask

  // One clock edge; div_load is only ever a single-cycle pulse.
  task automatic step();
    @(posedge clk);
    #1;
    t++;
    div_load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = '0;
    d = '0;
    div_load = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    t = 0;
  endtask

  function automatic bit in_seq(input int n, input int first, input int per);
    return (n >= first) && (((n - first) % per) == 0);
  endfunction

  // Divide values packed {ch3, ch2, ch1, ch0}.
  localparam logic [31:0] DIV_A = {8'd5, 8'd0, 8'd3, 8'd3};

  initial begin
    int  n;
    int  p3;
    int  p5;
    bit  q2_exp;
    bit  q2_next;

    p3 = int'(period_from_div(3));
    p5 = int'(period_from_div(5));

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    push("reset_state", 4'b0, ALL, 4'b0, ALL, 4'b0, ALL);
    check_now();

    // Test 1: run ch0 (div=3), reset asynchronously while ce is high.
    rst = 1'b0;
    t = 0;
    en = 4'b0001;
    d = 4'b0001;
    div_val = DIV_A;
    div_load = 1'b1;
    while (t < 25) begin
      n = t + 1;
      push("t1_run", {3'b0, in_seq(n, 17 + p3, p3)}, 4'b0001, {3'b0, n >= 22}, 4'b0001,
           4'b0001, 4'b0001);
      step();
      check_now();
    end
    rst = 1'b1;
    #1;
    push("t1_rst_async", 4'b0, ALL, 4'b0, ALL, 4'b0, ALL);
    check_now();
    @(posedge clk);
    @(posedge clk);
    #1;
    push("t1_rst_hold", 4'b0, ALL, 4'b0, ALL, 4'b0, ALL);
    check_now();
    rst = 1'b0;
    t = 0;
    div_load = 1'b1;
    while (t < 22) begin
      n = t + 1;
      push("t1_realign", {3'b0, in_seq(n, 17 + p3, p3)}, 4'b0001, {3'b0, n >= 22}, 4'b0001,
           4'b0001, 4'b0001);
      step();
      check_now();
    end

    // Test 2: staggered enables start together on the shared alignment edge.
    do_reset();
    div_val = DIV_A;
    div_load = 1'b1;
    while (t < 36) begin
      if (t == 5) en[0] = 1'b1;
      if (t == 9) en[1] = 1'b1;
      n = t + 1;
      push("t2_align", {2'b0, in_seq(n, 21, p3), in_seq(n, 21, p3)}, 4'b0011, 4'b0, 4'b0,
           {2'b0, n >= 10, n >= 6}, 4'b0011);
      step();
      check_now();
    end

    // Test 3: ch2 with div=0 pulses every cycle; q[2] follows d[2] one cycle late.
    en[2] = 1'b1;
    q2_exp = 1'b0;
    while (t < 64) begin
      d[2] = 1'($urandom_range(0, 1));
      q2_next = (t >= 50) ? d[2] : q2_exp;
      n = t + 1;
      push("t3_div0", {1'b0, n >= 50, 1'b0, in_seq(n, 21, p3)}, 4'b0101,
           {1'b0, q2_next, 2'b0}, 4'b0100, {1'b0, n >= 37, 2'b0}, 4'b0100);
      step();
      check_now();
      q2_exp = q2_next;
    end

    // Test 4: reprogram ch0 from div=7 to div=2 mid-period.
    do_reset();
    div_val = {8'd5, 8'd0, 8'd3, 8'd7};
    div_load = 1'b1;
    en = 4'b0001;
    while (t < 44) begin
      if (t == 28) begin
        div_val = {8'd5, 8'd0, 8'd3, 8'd2};
        div_load = 1'b1;
      end
      n = t + 1;
      push("t4_reprog", {3'b0, (n == 25) || in_seq(n, 33, int'(period_from_div(2)))}, 4'b0001,
           4'b0, 4'b0, 4'b0001, 4'b0001);
      step();
      check_now();
    end

    // Test 5: drain ch1 (div=5), then drop and re-assert en within one period.
    do_reset();
    div_val = {8'd5, 8'd0, 8'd5, 8'd3};
    div_load = 1'b1;
    en = 4'b0010;
    while (t < 74) begin
      if (t == 25) en[1] = 1'b0;
      if (t == 40) en[1] = 1'b1;
      if (t == 57) en[1] = 1'b0;
      if (t == 59) en[1] = 1'b1;
      n = t + 1;
      push("t5_drain", {2'b0, (n == 23) || (n == 23 + p5) || in_seq(n, 55, p5), 1'b0}, 4'b0010,
           4'b0, 4'b0, {2'b0, (n <= 28) || (n >= 41), 1'b0}, 4'b0010);
      step();
      check_now();
    end

    // Test 6: div_load on ch3's terminal-count edge.
    do_reset();
    div_val = DIV_A;
    div_load = 1'b1;
    en = 4'b1000;
    while (t < 44) begin
      if (t == 25) begin
        div_val[31:24] = 8'd2;
        div_load = 1'b1;
      end
      if (t == 28) begin
        div_val[31:24] = 8'd4;
        div_load = 1'b1;
      end
      n = t + 1;
      push("t6_tc_load", {(n == 23) || (n == 29) || (n == 32) || in_seq(n, 37, 5), 3'b0},
           4'b1000, 4'b0, 4'b0, 4'b1000, 4'b1000);
      step();
      check_now();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
